// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for the systolic-array loader: optional weight preload, then four
// feature loads (c11..c22) with drain gaps. Optional watchdog: SA_SCHED_TIMEOUT_EN.
module sa_tile_scheduler #(
   parameter logic [5:0] FEAT_BASE      = 6'd16,
   parameter logic [5:0] ROW_STRIDE     = 6'd4,
   parameter int         DRAIN_CYCLES   = 3,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       weight_reload,
   input  logic       wl_done_i,
   input  logic       fl_done_i,
   output logic       wp_en_o,
   output logic       fl_en_o,
   output logic       mode_o,
   output logic [5:0] feature_baseaddr_o,
   output logic [2:0] c_sel_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o
);

   // state   | meaning
   // IDLE    | waiting for start
   // WLOAD   | weight preloader running
   // FLOAD   | feature loader running for tile_idx
   // DRAIN   | letting the c_sel delay line settle
   // DONE    | one-cycle completion pulse

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WLOAD = 3'd1,
      S_FLOAD = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_t        state, state_nxt;
   logic [1:0]    tile_idx, tile_nxt;
   logic          weights_valid, wv_nxt;
   logic [DW-1:0] drain_cnt, drain_nxt;
   logic [5:0]    base_calc;

`ifdef SA_SCHED_TIMEOUT_EN
   localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [WD_W-1:0] wd_cnt;
   logic            wd_expired;
   logic            timeout;

   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

   assign base_calc = FEAT_BASE + (tile_nxt[1] ? ROW_STRIDE : 6'd0) + {5'd0, tile_nxt[0]};

   always_comb begin
      state_nxt = state;
      tile_nxt  = tile_idx;
      wv_nxt    = weights_valid;
      drain_nxt = drain_cnt;
`ifdef SA_SCHED_TIMEOUT_EN
      timeout   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               tile_nxt  = 2'd0;
               state_nxt = (weight_reload || !weights_valid) ? S_WLOAD : S_FLOAD;
            end
         end
         S_WLOAD: begin
            if (wl_done_i) begin
               wv_nxt    = 1'b1;
               state_nxt = S_FLOAD;
            end
`ifdef SA_SCHED_TIMEOUT_EN
            else if (wd_expired) begin
               timeout   = 1'b1;
               state_nxt = S_IDLE;
            end
`endif
         end
         S_FLOAD: begin
            if (fl_done_i) begin
               drain_nxt = DW'(DRAIN_CYCLES - 1);
               state_nxt = S_DRAIN;
            end
`ifdef SA_SCHED_TIMEOUT_EN
            else if (wd_expired) begin
               timeout   = 1'b1;
               state_nxt = S_IDLE;
            end
`endif
         end
         S_DRAIN: begin
            if (drain_cnt == '0) begin
               if (tile_idx == 2'd3) begin
                  state_nxt = S_DONE;
               end else begin
                  tile_nxt  = tile_idx + 2'd1;
                  state_nxt = S_FLOAD;
               end
            end else begin
               drain_nxt = drain_cnt - 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= S_IDLE;
         tile_idx           <= 2'd0;
         weights_valid      <= 1'b0;
         drain_cnt          <= '0;
         wp_en_o            <= 1'b0;
         fl_en_o            <= 1'b0;
         mode_o             <= 1'b0;
         feature_baseaddr_o <= 6'd0;
         c_sel_o            <= 3'd0;
         busy_o             <= 1'b0;
         done_o             <= 1'b0;
      end else begin
         state         <= state_nxt;
         tile_idx      <= tile_nxt;
         weights_valid <= wv_nxt;
         drain_cnt     <= drain_nxt;
         wp_en_o       <= (state_nxt == S_WLOAD);
         fl_en_o       <= (state_nxt == S_FLOAD);
         busy_o        <= (state_nxt != S_IDLE);
         done_o        <= (state_nxt == S_DONE);
         if (state_nxt == S_WLOAD) begin
            mode_o <= 1'b0;
         end else if (state_nxt == S_FLOAD) begin
            mode_o             <= 1'b1;
            c_sel_o            <= {1'b0, tile_nxt};
            feature_baseaddr_o <= base_calc;
         end
      end
   end

`ifdef SA_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
         err_o  <= 1'b0;
      end else begin
         err_o <= timeout;
         if (state_nxt != state || !(state == S_WLOAD || state == S_FLOAD))
            wd_cnt <= '0;
         else
            wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: doc/sa_tile_scheduler.md
# sa_tile_scheduler

Sequencer for the systolic-array data loader (`top_sa_loader`). On a `start` pulse it optionally preloads the 3x3 weight set, then runs four feature loads, one per 2x2 output element (c11, c12, c21, c22). For each load it drives the loader enables, the shared-RAM address mode, the feature base address and the output-register select. It sits between the top-level control FSM and `top_sa_loader`, and handshakes only on the loaders' done flags.

## Interface
Parameters:
- `FEAT_BASE`, default 6'd16: RAM address of the first feature word (weights occupy 0..8).
- `ROW_STRIDE`, default 6'd4: address distance between feature rows.
- `DRAIN_CYCLES`, default 3: idle cycles after each feature load. Covers the 3-stage `c_sel` delay line.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `SA_SCHED_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to run a tile. Sampled only in IDLE.
- `weight_reload` in 1: sampled with `start`. 1 forces a weight preload.
- `wl_done_i` in 1: `is_WL_done_o` from the loader.
- `fl_done_i` in 1: `is_FL_done_o` from the loader.
- `wp_en_o` out 1: drives `Weight_Preloader_en`.
- `fl_en_o` out 1: drives `Feature_Loader_en`.
- `mode_o` out 1: RAM address mux select. 0 = weight, 1 = feature.
- `feature_baseaddr_o` out 6: drives `feature_baseaddr`.
- `c_sel_o` out 3: output register select, 3'd0..3'd3 = c11, c12, c21, c22.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when the tile completes.
- `err_o` out 1: one-cycle watchdog pulse. Tied 0 without the macro.

## Operation
- All outputs are registered.
- States: IDLE, WLOAD, FLOAD, DRAIN, DONE.
- Internal registers:
  - `weights_valid`: cleared by reset, set when WLOAD completes.
  - 2-bit `tile_idx`.
  - Drain counter.
- IDLE:
  - On `start`, clear `tile_idx`.
  - Go to WLOAD if `weight_reload` is 1 or `weights_valid` is 0.
  - Otherwise go to FLOAD.
- WLOAD:
  - Outputs: `wp_en_o`=1, `mode_o`=0, `fl_en_o`=0.
  - On `wl_done_i`, set `weights_valid` and go to FLOAD.
- FLOAD:
  - Outputs: `fl_en_o`=1, `mode_o`=1, `c_sel_o`={1'b0,`tile_idx`}.
  - `feature_baseaddr_o` = `FEAT_BASE` + (`tile_idx`[1] ? `ROW_STRIDE` : 0) + `tile_idx`[0], modulo 64 (6-bit wrap, carry discarded).
  - On `fl_done_i`, go to DRAIN and load the drain counter with `DRAIN_CYCLES`-1.
- DRAIN:
  - `fl_en_o`=0. `c_sel_o`, `mode_o` and `feature_baseaddr_o` hold their values.
  - Count down. At 0: if `tile_idx`==3 go to DONE, otherwise increment `tile_idx` and go to FLOAD.
- DONE:
  - `done_o`=1 for this cycle only, then go to IDLE.
- Done flags:
  - `wl_done_i` and `fl_done_i` are ignored outside WLOAD and FLOAD respectively.
  - A done flag that is already high on the state's first cycle completes that state immediately.
- Busy and restart:
  - `start` while busy is ignored; it is not queued.
  - `start` asserted in the same cycle as `done_o` is ignored, because the FSM is still in DONE.

## Timing
- Reset values: state IDLE, and every output 0 (`wp_en_o`, `fl_en_o`, `mode_o`, `feature_baseaddr_o`, `c_sel_o`, `busy_o`, `done_o`, `err_o`). `weights_valid`=0.
- A reset mid-operation drops all enables in the same cycle (asynchronous) and returns the FSM to IDLE.
- `start` at edge N: `busy_o` and the first-state enables appear after edge N.
- A done flag seen at edge M: the enable drops after edge M; the next state's outputs are valid after edge M.
- `mode_o` changes on the same edge as the enable it accompanies.
- Per-tile overhead outside the loaders: 1 FLOAD-exit cycle plus `DRAIN_CYCLES`.
- Minimum total latency, with a zero-wait loader and no preload: 4×(1+`DRAIN_CYCLES`)+2 cycles from `start` to `done_o`.

## Configuration
- Macro: `SA_SCHED_TIMEOUT_EN`.
- Defined:
  - An 8-bit+ watchdog counter clears on every state entry and counts while in WLOAD or FLOAD.
  - On reaching `TIMEOUT_CYCLES`: drop the enables, pulse `err_o`, go to IDLE, no `done_o`.
  - A timeout in WLOAD leaves `weights_valid` unchanged.
- Undefined: no counter; `err_o` is constant 0; WLOAD and FLOAD wait indefinitely.

## Test plan
- Reset, then `start` with `weight_reload`=1, loader done 5 cycles after each enable.
  - Expect `wp_en_o` high with `mode_o`=0.
  - Then 4 FLOADs with `c_sel_o`=0,1,2,3 and bases 16, 17, 20, 21.
  - Each FLOAD followed by 3 drain cycles, then a single `done_o` pulse.
- Second `start` with `weight_reload`=0 → WLOAD is skipped; the first cycle after `start` shows `fl_en_o`=1 with base 16.
- `FEAT_BASE`=6'd62, `ROW_STRIDE`=4 → bases 62, 63, 2, 3 (wrap-around).
- `start` pulses during FLOAD → ignored; exactly one `done_o` per accepted start.
- `rst` asserted mid-FLOAD → all outputs 0 immediately; the next `start` performs a weight preload because `weights_valid` was cleared.
- With `SA_SCHED_TIMEOUT_EN` and `fl_done_i` held 0 → `err_o` pulses once after 255 cycles, `fl_en_o` drops, FSM in IDLE, no `done_o`.
